cam_dvp_capture: RTL
====================

# cam_dvp_capture

Receive side of the DVP camera port. Samples `cam_vsync`/`cam_href`/`cam_data` on the rising edge of `cam_pclk`, frames the stream into lines and frames, packs bytes into 32-bit words and delivers them through a small internal FIFO on a valid/ready stream toward the DMA/bus side. Runs entirely in the pixel-clock domain. It is the counterpart of the camera stimulus model that drives data on the falling edge.

## Interface

Parameters:
- `FRAME_WIDTH`, 4: pixels per line. Expected bytes per line = 2·`FRAME_WIDTH`, a multiple of 4.
- `FRAME_HEIGHT`, 4: lines per frame.
- `FIFO_DEPTH`, 8: words in the output FIFO. Must be a power of 2, at least 2.

Ports:
- `cam_pclk`, in, 1: pixel clock. All logic is on the rising edge.
- `cam_rstn`, in, 1: reset, asynchronous, active-low.
- `cam_vsync`, in, 1: frame sync, active high.
- `cam_href`, in, 1: line valid, active high.
- `cam_data`, in, 8: pixel byte.
- `cfg_en`, in, 1: capture enable. Sampled only in IDLE.
- `err_clr`, in, 1: one-cycle pulse that clears the sticky error flags.
- `pix_data`, out, 32: packed word. The first byte of the word is in [7:0].
- `pix_valid`, out, 1: word available.
- `pix_ready`, in, 1: consumer accepts the word.
- `pix_last`, out, 1: the current word is the last word of the frame.
- `frame_done`, out, 1: one-cycle pulse when the last word of the frame is written into the FIFO.
- `ovf_err`, out, 1: sticky flag; a word was dropped because the FIFO was full.
- `size_err`, out, 1: sticky flag; a line length or line count did not match the parameters.
- `frame_cnt`, out, 16: number of frames completed.

## Operation

- Input stage: `cam_vsync`/`cam_href`/`cam_data` are registered on every edge. All decisions below use the registered copies, and edges are detected against the previous registered value.
- State machine:
  - IDLE: moves to SYNC when `cfg_en`=1 and vsync shows a rising edge.
  - SYNC: moves to ACTIVE on the vsync falling edge. The line count is cleared on entry.
  - ACTIVE: moves to LINE when href=1. A vsync rising edge here sets `size_err` and goes to SYNC; the partial frame is abandoned.
  - LINE: each href=1 cycle shifts one byte into the packer.
    - A completed 4-byte group is written to the FIFO.
    - When href falls, check the byte count. If it is not 2·`FRAME_WIDTH`, set `size_err`; any partial group is written zero-filled in its upper bytes.
    - Increment the line count, then go to ACTIVE. If the count reaches `FRAME_HEIGHT`, go to DONE instead.
  - DONE: lasts one cycle. Increment `frame_cnt` (wraps 0xFFFF→0), then go to IDLE. If `cfg_en`=0, stop there; otherwise the next vsync rising edge starts the next frame.
- `pix_last` is stored in the FIFO alongside the word. It is set on the final word of line `FRAME_HEIGHT`.
- Full FIFO: the word is discarded and `ovf_err` is set. Packing and counting continue unaffected.
- Sticky flags: `err_clr` clears `ovf_err` and `size_err`. A new error event in the same cycle wins, so the flag stays 1.
- Dropping `cfg_en` mid-frame has no effect until the frame finishes.

## Timing

- Reset values:
  - all outputs 0;
  - FSM in IDLE;
  - FIFO empty;
  - packer and all counters at 0.
- Latency: let byte 4 of a group be registered at edge N.
  - The FIFO write happens at edge N+1.
  - `pix_valid`=1 after edge N+2 if the FIFO was empty.
  - `frame_done` pulses in the cycle following the final write.
- Handshake:
  - A transfer happens on any edge with `pix_valid`&&`pix_ready`.
  - `pix_data`/`pix_last` stay stable while `pix_valid`=1 and `pix_ready`=0.
  - A simultaneous read and write on a full FIFO is accepted; nothing is dropped.
- Asynchronous reset mid-frame discards the FIFO contents and returns the block to IDLE immediately.

## Configuration

- `CAM_DVP_CAPTURE_STATS_EN` defined: `frame_cnt` is implemented and counts as described above.
- Not defined: the counter is not implemented and `frame_cnt` is tied to 0. All other behaviour is identical.

## Structure

- Shared package `cam_pkg`:
  - FSM state enum (IDLE, SYNC, ACTIVE, LINE, DONE);
  - typedef of the FIFO entry struct {last, data[31:0]}.
- Sub-module `cam_dvp_fifo`: synchronous single-clock FIFO parameterised by depth and entry type. It provides full/empty and registered outputs.

## Test plan

- Defaults, `pix_ready`=1. Drive one frame where each line carries bytes 0x00..0x07.
  - Expect 8 words, alternating 0x03020100 / 0x07060504.
  - `pix_last` set only on word 8; one `frame_done` pulse; `frame_cnt`=1; no error flags.
- Hold `pix_ready`=0 for a full frame.
  - Words 1-8 fill the FIFO with no overflow.
  - A second frame sets `ovf_err`, and the first 8 words are read back unchanged.
- One line carries only 6 bytes.
  - Expect `size_err`=1 and a word 0x00000504 for the short tail.
  - The line count still advances.
- vsync rises after 2 lines.
  - `size_err` is set, no `frame_done`, and the next full frame captures correctly.
- Assert `cam_rstn` in the middle of line 3.
  - All outputs drop to 0 at once; the next frame yields exactly 8 words.
- `cfg_en`=0 while vsync pulses: nothing is written and `frame_cnt` stays at 0.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types for the DVP capture block: FSM state encoding and FIFO entry layout.
package cam_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_ACTIVE,
    ST_LINE,
    ST_DONE
  } cam_state_t;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/cam_dvp_fifo.sv
// Single-clock FIFO with a registered output stage; DEPTH counts the output register too.
module cam_dvp_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter type entry_t = logic [7:0]
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   wr_en,
  input  entry_t wr_data,
  output logic   full,
  input  logic   rd_ready,
  output logic   rd_valid,
  output entry_t rd_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned USE_W = PTR_W + 1;

  entry_t mem [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [USE_W-1:0] used, used_nxt;
  logic rd, push, mem_has, pop;

  // A full FIFO still accepts a write when the head is leaving in the same cycle.
  always_comb begin
    rd       = rd_valid & rd_ready;
    push     = wr_en & (~full | rd);
    mem_has  = used != USE_W'(rd_valid);
    pop      = mem_has & (~rd_valid | rd);
    used_nxt = used + USE_W'(push) - USE_W'(rd);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      used     <= '0;
      full     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      used <= used_nxt;
      full <= used_nxt == USE_W'(DEPTH);
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop) begin
        rd_data  <= mem[rptr];
        rptr     <= rptr + PTR_W'(1);
        rd_valid <= 1'b1;
      end else if (rd) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cam_dvp_capture.sv
// DVP camera receiver: frames vsync/href/data into lines, packs bytes into 32-bit words, streams them out.
// Optional frame counter enabled by defining CAM_DVP_CAPTURE_STATS_EN.
module cam_dvp_capture
  import cam_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH  = 4,
  parameter int unsigned FRAME_HEIGHT = 4,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        cam_pclk,
  input  logic        cam_rstn,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        cfg_en,
  input  logic        err_clr,
  output logic [31:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_last,
  output logic        frame_done,
  output logic        ovf_err,
  output logic        size_err,
  output logic [15:0] frame_cnt
);

  localparam int unsigned LINE_BYTES = 2 * FRAME_WIDTH;

  cam_state_t       state;
  logic             vs_q, vs_d1, hr_q;
  logic [7:0]       data_q;
  logic [23:0]      pack;
  logic [1:0]       pos;
  logic [CNT_W-1:0] byte_cnt, line_cnt;
  logic             fifo_full;
  fifo_entry_t      wr_entry, rd_entry;
  logic vs_rise, vs_fall, take_byte, line_end, group_done, wr_en, ovf_ev, size_ev;

  always_ff @(posedge cam_pclk or negedge cam_rstn) begin
    if (!cam_rstn) begin
      vs_q   <= 1'b0;
      vs_d1  <= 1'b0;
      hr_q   <= 1'b0;
      data_q <= '0;
    end else begin
      vs_q   <= cam_vsync;
      vs_d1  <= vs_q;
      hr_q   <= cam_href;
      data_q <= cam_data;
    end
  end

  // The first byte of a line arrives in ACTIVE, so ACTIVE shifts it in as well.
  always_comb begin
    vs_rise    = vs_q & ~vs_d1;
    vs_fall    = ~vs_q & vs_d1;
    take_byte  = hr_q & ((state == ST_LINE) | ((state == ST_ACTIVE) & ~vs_rise));
    line_end   = (state == ST_LINE) & ~hr_q;
    group_done = take_byte & (pos == 2'd3);
    wr_en      = group_done | (line_end & (pos != 2'd0));
    wr_entry   = '0;
    wr_entry.data = group_done ? {data_q, pack} : {8'h00, pack};
    wr_entry.last = (line_cnt == CNT_W'(FRAME_HEIGHT - 1)) &
                    (~group_done | (byte_cnt + CNT_W'(1) == CNT_W'(LINE_BYTES)));
    ovf_ev     = wr_en & fifo_full & ~(pix_valid & pix_ready);
    size_ev    = ((state == ST_ACTIVE) & vs_rise) |
                 (line_end & (byte_cnt != CNT_W'(LINE_BYTES)));
  end

  always_ff @(posedge cam_pclk or negedge cam_rstn) begin
    if (!cam_rstn) begin
      state      <= ST_IDLE;
      pack       <= '0;
      pos        <= '0;
      byte_cnt   <= '0;
      line_cnt   <= '0;
      frame_done <= 1'b0;
      ovf_err    <= 1'b0;
      size_err   <= 1'b0;
    end else begin
      frame_done <= wr_en & wr_entry.last;
      ovf_err    <= ovf_ev | (ovf_err & ~err_clr);
      size_err   <= size_ev | (size_err & ~err_clr);
      if (take_byte) begin
        unique case (pos)
          2'd0:    pack[7:0]   <= data_q;
          2'd1:    pack[15:8]  <= data_q;
          2'd2:    pack[23:16] <= data_q;
          default: pack        <= '0;
        endcase
        pos      <= pos + 2'd1;
        byte_cnt <= byte_cnt + CNT_W'(1);
      end
      unique case (state)
        ST_IDLE: if (cfg_en && vs_rise) begin
          state    <= ST_SYNC;
          line_cnt <= '0;
        end
        ST_SYNC: if (vs_fall) state <= ST_ACTIVE;
        ST_ACTIVE: begin
          if (vs_rise) begin
            state    <= ST_SYNC;
            line_cnt <= '0;
          end else if (hr_q) begin
            state <= ST_LINE;
          end
        end
        ST_LINE: if (!hr_q) begin
          pack     <= '0;
          pos      <= '0;
          byte_cnt <= '0;
          line_cnt <= line_cnt + CNT_W'(1);
          state    <= (line_cnt + CNT_W'(1) == CNT_W'(FRAME_HEIGHT)) ? ST_DONE : ST_ACTIVE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CAM_DVP_CAPTURE_STATS_EN
  always_ff @(posedge cam_pclk or negedge cam_rstn) begin
    if (!cam_rstn) frame_cnt <= '0;
    else if (state == ST_DONE) frame_cnt <= frame_cnt + 16'd1;
  end
`else
  assign frame_cnt = '0;
`endif

  cam_dvp_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fifo_entry_t)
  ) u_fifo (
    .clk      (cam_pclk),
    .rst_n    (cam_rstn),
    .wr_en    (wr_en),
    .wr_data  (wr_entry),
    .full     (fifo_full),
    .rd_ready (pix_ready),
    .rd_valid (pix_valid),
    .rd_data  (rd_entry)
  );

  assign pix_data = rd_entry.data;
  assign pix_last = rd_entry.last;

endmodule
